fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               NOP_INSTR     - bubble word loaded into IF/ID (addi x0,x0,0)
//               fetch_state_t - request FSM state (RUN / DRAIN)
//               fetch_entry_t - prefetch FIFO entry {instr, pc}
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO, no bypass. A push while full is
//               accepted only together with a pop. clear empties the FIFO.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               clear        - drop all entries
//               push, din    - enqueue request and data
//               pop          - dequeue request (ignored when empty)
//               dout         - head entry (valid when !empty)
//               count, empty - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [CW-1:0] c_cnt_max = CW'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    assign empty  = (r_count == '0);
    assign w_full = (r_count == c_cnt_max);
    assign w_pop  = pop & ~empty;
    // A pop frees the head slot at this edge, so a full FIFO may take a push.
    assign w_push = push & (~w_full | w_pop);
    assign dout   = r_mem[r_rd_ptr];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32 instruction fetch with prefetch FIFO and IF/ID register.
//               Requests are credit-limited to DEPTH (outstanding + buffered),
//               responses return in order; on a redirect the in-flight
//               responses are counted off in DRAIN and discarded.
// Ports       : clk, reset                  - clock, sync active-high reset
//               imem_req_valid/ready/addr   - fetch request handshake
//               imem_rsp_valid/data         - in-order response beats
//               StallD, FlushD              - hazard unit controls for IF/ID
//               PCSrcE, PCTargetE           - taken branch / jump redirect
//               InstrD, PCD, PCPlus4D, ValidD - IF/ID register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] c_credit_lim = (CW + 1)'(DEPTH);

    fetch_state_t   r_state;
    logic [31:0]    r_pcf;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_drop;

    fetch_entry_t   w_fifo_din;
    fetch_entry_t   w_fifo_head;
    logic [CW-1:0]  w_fifo_count;
    logic           w_fifo_empty;
    logic           w_deq;
    logic [CW:0]    w_used;
    logic           w_issue;
    logic           w_fire;
    logic [CW-1:0]  w_pend;
    logic           w_rsp_hit;
    logic           w_rsp_accept;
    logic [CW-1:0]  w_drop_next;

    // IF/ID pulls from the FIFO only when neither flushed nor stalled.
    assign w_deq = ~FlushD & ~StallD & ~w_fifo_empty;

    // Credits already committed once this cycle's dequeue is taken out.
    assign w_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count}
                   - {{CW{1'b0}}, w_deq};
    assign w_issue = ~reset & ~PCSrcE & (r_state == RUN) & (w_used < c_credit_lim);
    assign w_fire  = w_issue & imem_req_ready;

    assign imem_req_valid = w_issue;
    assign imem_req_addr  = r_pcf;

    // Only one of outstanding / drop is non-zero at a time, so their sum is
    // the number of beats still owed by memory.
    assign w_pend       = r_outstanding + r_drop;
    assign w_rsp_hit    = imem_rsp_valid & (w_pend != '0);
    assign w_rsp_accept = w_rsp_hit & ~PCSrcE & (r_state == RUN);
    assign w_drop_next  = w_pend - {{(CW-1){1'b0}}, w_rsp_hit};

    // The oldest in-flight request was issued outstanding words behind PCF.
    assign w_fifo_din.instr = imem_rsp_data;
    assign w_fifo_din.pc    = r_pcf - (32'(r_outstanding) << 2);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (PCSrcE),
        .push  (w_rsp_accept),
        .din   (w_fifo_din),
        .pop   (w_deq),
        .dout  (w_fifo_head),
        .count (w_fifo_count),
        .empty (w_fifo_empty)
    );

    // PC, credit counters and request FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pcf         <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (PCSrcE) begin
            r_pcf         <= PCTargetE;
            r_outstanding <= '0;
            r_drop        <= w_drop_next;
            r_state       <= (w_drop_next != '0) ? DRAIN : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_fire) begin
                        r_pcf <= r_pcf + 32'd4;
                    end
                    r_outstanding <= r_outstanding
                                   + {{(CW-1){1'b0}}, w_fire}
                                   - {{(CW-1){1'b0}}, w_rsp_accept};
                end
                DRAIN: begin
                    if (w_rsp_hit) begin
                        r_drop <= w_drop_next;
                        if (w_drop_next == '0) begin
                            r_state <= RUN;
                        end
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
        end else if (!w_fifo_empty) begin
            InstrD   <= w_fifo_head.instr;
            PCD      <= w_fifo_head.pc;
            PCPlus4D <= w_fifo_head.pc + 32'd4;
            ValidD   <= 1'b1;
        end else begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
        end
    end

    // A beat with nothing owed is a memory protocol error; the RTL ignores it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && (w_pend == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. An in-order memory model
//               with configurable latency returns addr ^ 0xA5A5_0000; the
//               expected PC stream is queued by the directed sequence and
//               popped whenever a new instruction appears in IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc  = 0;
    int    lat  = 1;
    int    acc8 = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            acc8 = 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (imem_rsp_valid && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + lat});
                if (imem_req_addr == 32'h8) begin
                    acc8 = acc8 + 1;
                end
            end
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq[0].addr ^ KEY;
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        stall_e = 1'b0;

    always @(posedge clk) stall_e <= StallD;

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && ValidD === 1'b1 && !stall_e) begin
            n_checks = n_checks + 1;
            assert (exp_q.size() > 0) n_pass = n_pass + 1;
            else $error("FAIL sb_empty: observed PCD %h, expected no new instruction", PCD);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pops = n_pops + 1;
                chk("sb_pcd", PCD, e);
                chk("sb_instr", InstrD, e ^ KEY);
                chk("sb_pcplus4", PCPlus4D, e + 32'd4);
            end
        end
    end

    task automatic sb_restart(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr"}, InstrD, NOP_INSTR);
        chk({tag, "_pcd"}, PCD, 32'h0);
        chk({tag, "_pcplus4"}, PCPlus4D, 32'h0);
        chk({tag, "_valid"}, 32'(ValidD), 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        StallD         = 1'b0;
        FlushD         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;
        lat            = 1;

        repeat (3) tick();
        @(negedge clk);
        chk_reset_outputs("rst");
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);

        // Segment A: zero-wait memory, stall, flush+stall.
        tick(); reset = 1'b0; sb_restart(32'h0, 64);                 // c0
        @(negedge clk);
        chk("a_c0_req_valid", 32'(imem_req_valid), 32'h1);
        chk("a_c0_req_addr", imem_req_addr, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            @(negedge clk);
            chk("a_validd", 32'(ValidD), (c >= 3) ? 32'h1 : 32'h0);
            if (c >= 3 && c <= 5) begin
                chk("a_pcd", PCD, 32'(4 * (c - 3)));
            end
        end
        tick(); StallD = 1'b1;                                      // c8
        @(negedge clk);
        chk("stall1_pcd", PCD, 32'h14);
        chk("stall1_req_valid", 32'(imem_req_valid), 32'h0);
        tick();                                                     // c9
        @(negedge clk);
        chk("stall2_pcd", PCD, 32'h14);
        chk("stall2_instr", InstrD, 32'h14 ^ KEY);
        chk("stall2_req_valid", 32'(imem_req_valid), 32'h0);
        tick(); StallD = 1'b0;                                      // c10
        @(negedge clk);
        chk("stall_held_pcd", PCD, 32'h14);
        tick();                                                     // c11
        @(negedge clk);
        chk("resume_pcd", PCD, 32'h18);
        repeat (2) tick();                                          // c12,c13
        tick(); FlushD = 1'b1; StallD = 1'b1;                       // c14
        @(negedge clk);
        chk("pre_flush_pcd", PCD, 32'h24);
        tick(); FlushD = 1'b0; StallD = 1'b0;                       // c15
        @(negedge clk);
        chk("flushstall_instr", InstrD, NOP_INSTR);
        chk("flushstall_valid", 32'(ValidD), 32'h0);
        tick();                                                     // c16
        @(negedge clk);
        chk("post_flush_pcd", PCD, 32'h28);
        tick(); reset = 1'b1;                                       // c17
        @(negedge clk);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);

        // Segment B: reset recovery, then ready held low with PCF=0x8.
        tick(); reset = 1'b0; sb_restart(32'h0, 64);                 // b0
        @(negedge clk);
        chk_reset_outputs("midrst");
        chk("b_c0_req_valid", 32'(imem_req_valid), 32'h1);
        chk("b_c0_req_addr", imem_req_addr, 32'h0);
        tick();                                                     // b1
        tick(); imem_req_ready = 1'b0;                              // b2
        for (int c = 2; c <= 4; c++) begin
            if (c > 2) tick();
            @(negedge clk);
            chk("nordy_req_valid", 32'(imem_req_valid), 32'h1);
            chk("nordy_req_addr", imem_req_addr, 32'h8);
        end
        tick(); imem_req_ready = 1'b1;                              // b5
        @(negedge clk);
        chk("rdy_req_addr", imem_req_addr, 32'h8);
        repeat (8) tick();
        @(negedge clk);
        chk("accept_count_0x8", 32'(acc8), 32'h1);

        // Segment C: 3-cycle latency, redirect with two requests in flight.
        tick(); reset = 1'b1; lat = 3;
        repeat (2) tick();
        tick(); reset = 1'b0; sb_restart(32'h0, 16);                 // c0
        repeat (5) tick();                                          // c1..c5
        tick(); PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1;  // c6
        @(negedge clk);
        chk("redir_req_valid", 32'(imem_req_valid), 32'h0);
        chk("redir_pcd", PCD, 32'h4);
        tick(); PCSrcE = 1'b0; FlushD = 1'b0; sb_restart(32'h100, 16); // c7
        @(negedge clk);
        chk("drain1_req_valid", 32'(imem_req_valid), 32'h0);
        chk("flush_validd", 32'(ValidD), 32'h0);
        tick();                                                     // c8
        @(negedge clk);
        chk("drain2_req_valid", 32'(imem_req_valid), 32'h0);
        tick();                                                     // c9
        @(negedge clk);
        chk("target_req_valid", 32'(imem_req_valid), 32'h1);
        chk("target_req_addr", imem_req_addr, 32'h100);
        for (int c = 10; c <= 13; c++) begin
            tick();
            @(negedge clk);
            chk("drain_bubble_validd", 32'(ValidD), 32'h0);
        end
        tick();                                                     // c14
        @(negedge clk);
        chk("target_validd", 32'(ValidD), 32'h1);
        chk("target_pcd", PCD, 32'h100);
        repeat (10) tick();
        @(negedge clk);
        chk("sb_activity", 32'(n_pops >= 20), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
